fpu_fcsr: RTL

//  Floating-point control/status register. Consumes the five per-op exception

---
 rtl/fpu_fcsr_pkg.sv | 42 ++++
 rtl/fpu_flag_pipe.sv | 42 ++++
 rtl/fpu_fcsr.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fpu_fcsr_pkg.sv
// Shared types and constants for the floating-point control/status register block.
package fpu_fcsr_pkg;

  localparam int unsigned CSR_ADDR_W  = 12;
  localparam int unsigned CSR_DATA_W  = 32;
  localparam int unsigned FFLAGS_W    = 5;
  localparam int unsigned FRM_W       = 3;
  localparam int unsigned FCSR_W      = FFLAGS_W + FRM_W;

  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FFLAGS = 12'h001;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FRM    = 12'h002;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [FRM_W-1:0] {
    FRM_RNE = 3'd0,
    FRM_RTZ = 3'd1,
    FRM_RDN = 3'd2,
    FRM_RUP = 3'd3,
    FRM_RMM = 3'd4
  } frm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Encodings above RMM are reserved and must not reach the rounding stage.
  function automatic logic frm_is_illegal(input logic [FRM_W-1:0] frm);
    return frm > FRM_W'(FRM_RMM);
  endfunction

endpackage

// File: rtl/fpu_flag_pipe.sv
// Pending-flag delay line: holds captured exception flags for DEPTH cycles so
// a speculative op can still be killed before its flags become sticky.
module fpu_flag_pipe
  import fpu_fcsr_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    capture_i,
  input  fflags_t flags_i,
  input  logic    kill_i,
  output logic    commit_c,
  output fflags_t commit_flags_c,
  output logic    pending_c
);

  logic [DEPTH-1:0]    valid_q;
  fflags_t [DEPTH-1:0] flags_q;

  // Kill drops every stage including the one being loaded this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      flags_q <= '0;
    end else begin
      valid_q[0] <= capture_i & ~kill_i;
      if (capture_i) begin
        flags_q[0] <= flags_i;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1] & ~kill_i;
        flags_q[i] <= flags_q[i-1];
      end
    end
  end

  assign commit_c       = valid_q[DEPTH-1] & ~kill_i;
  assign commit_flags_c = flags_q[DEPTH-1];
  assign pending_c      = |valid_q;

endmodule

// File: rtl/fpu_fcsr.sv
// Floating-point CSR: sticky exception flags, dynamic rounding mode and the
// CSR access handshake that drains in-flight flags before each access.
module fpu_fcsr
  import fpu_fcsr_pkg::*;
#(
  parameter int unsigned             FLAG_PIPE   = 1,
  parameter logic [CSR_ADDR_W-1:0]   ADDR_FFLAGS = CSR_ADDR_FFLAGS,
  parameter logic [CSR_ADDR_W-1:0]   ADDR_FRM    = CSR_ADDR_FRM,
  parameter logic [CSR_ADDR_W-1:0]   ADDR_FCSR   = CSR_ADDR_FCSR
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flag_valid_i,
  output logic                  flag_ready_o,
  input  logic                  invalid_i,
  input  logic                  div_zero_i,
  input  logic                  overflow_i,
  input  logic                  underflow_i,
  input  logic                  inexact_i,
  input  logic                  flag_kill_i,
  input  logic                  csr_req_i,
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  input  logic [1:0]            csr_op_i,
  input  logic [CSR_DATA_W-1:0] csr_wdata_i,
  output logic [CSR_DATA_W-1:0] csr_rdata_o,
  output logic                  csr_ack_o,
  output logic                  csr_err_o,
  output logic [FFLAGS_W-1:0]   fflags_o,
  output logic [FRM_W-1:0]      frm_o,
  output logic                  frm_illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  fflags_t             fflags_q;
  logic [FRM_W-1:0]    frm_q;
  logic                frm_illegal_q;
  logic                ready_q;
  logic                ack_q;
  logic                err_q;
  logic [CSR_DATA_W-1:0] rdata_q;

  logic                capture_c;
  fflags_t             cap_flags_c;
  logic                commit_c;
  fflags_t             commit_flags_c;
  logic                pending_c;

  logic                hit_fflags_c, hit_frm_c, hit_fcsr_c, addr_err_c;
  logic [FCSR_W-1:0]   old_c, operand_c, new_c;
  logic                exec_c, wr_fflags_c, wr_frm_c;
  logic [FRM_W-1:0]    frm_new_c;
  logic                unused_wdata_c;

  assign capture_c   = flag_valid_i & ready_q;
  assign cap_flags_c = '{nv: invalid_i, dz: div_zero_i, of: overflow_i,
                         uf: underflow_i, nx: inexact_i};

  fpu_flag_pipe #(
    .DEPTH (FLAG_PIPE)
  ) u_flag_pipe (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .capture_i      (capture_c),
    .flags_i        (cap_flags_c),
    .kill_i         (flag_kill_i),
    .commit_c       (commit_c),
    .commit_flags_c (commit_flags_c),
    .pending_c      (pending_c)
  );

  // Access sequencing; a same-cycle capture also counts as in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (csr_req_i) begin
          state_d = (pending_c || capture_c) ? S_DRAIN : S_EXEC;
        end
      end
      S_DRAIN: begin
        if (!pending_c) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read-modify-write datapath, only the low FCSR_W bits carry state.
  always_comb begin
    hit_fflags_c = (csr_addr_i == ADDR_FFLAGS);
    hit_frm_c    = (csr_addr_i == ADDR_FRM);
    hit_fcsr_c   = (csr_addr_i == ADDR_FCSR);
    addr_err_c   = ~(hit_fflags_c | hit_frm_c | hit_fcsr_c);
    operand_c    = csr_wdata_i[FCSR_W-1:0];
    old_c        = '0;
    if (hit_fflags_c) begin
      old_c = FCSR_W'(fflags_q);
    end else if (hit_frm_c) begin
      old_c = FCSR_W'(frm_q);
    end else if (hit_fcsr_c) begin
      old_c = {frm_q, fflags_q};
    end
    unique case (csr_op_e'(csr_op_i))
      CSR_WRITE: new_c = operand_c;
      CSR_SET:   new_c = old_c | operand_c;
      CSR_CLEAR: new_c = old_c & ~operand_c;
      default:   new_c = old_c;
    endcase
    exec_c      = (state_q == S_EXEC);
    wr_fflags_c = exec_c & (hit_fflags_c | hit_fcsr_c);
    wr_frm_c    = exec_c & (hit_frm_c | hit_fcsr_c);
    frm_new_c   = hit_fcsr_c ? new_c[FCSR_W-1:FFLAGS_W] : new_c[FRM_W-1:0];
  end

  assign unused_wdata_c = ^csr_wdata_i[CSR_DATA_W-1:FCSR_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q      <= '0;
      frm_q         <= FRM_W'(FRM_RNE);
      frm_illegal_q <= 1'b0;
    end else begin
      if (wr_fflags_c) begin
        fflags_q <= fflags_t'(new_c[FFLAGS_W-1:0]);
      end else if (commit_c) begin
        fflags_q <= fflags_q | commit_flags_c;
      end
      if (wr_frm_c) begin
        frm_q         <= frm_new_c;
        frm_illegal_q <= frm_is_illegal(frm_new_c);
      end
    end
  end

  // Response and flag-ready registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= (state_d == S_IDLE);
      ack_q   <= exec_c;
      err_q   <= exec_c & addr_err_c;
      if (exec_c) begin
        rdata_q <= addr_err_c ? '0 : CSR_DATA_W'(old_c);
      end
    end
  end

  assign flag_ready_o  = ready_q;
  assign csr_ack_o     = ack_q;
  assign csr_err_o     = err_q;
  assign csr_rdata_o   = rdata_q;
  assign fflags_o      = fflags_q;
  assign frm_o         = frm_q;
  assign frm_illegal_o = frm_illegal_q;

endmodule
